// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream feeder and the CRC control unit:
// write-size codes on the CRC write interface and the feeder FSM encoding.
package crc_pkg;

  // Write-size codes understood by the CRC unit.
  localparam logic [1:0] SIZE_BYTE      = 2'b00;
  localparam logic [1:0] SIZE_HALF_WORD = 2'b01;
  localparam logic [1:0] SIZE_WORD      = 2'b10;

  // Feeder sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SPLIT  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FINISH = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/crc_tail_slicer.sv
// Combinational write slicer: from the bytes still owed to the CRC unit, the
// split phase and the fetched word, choose the write size, the LSB-justified
// write data and how many bytes that write consumes. A 3-byte tail is sent as
// a half-word followed (split phase) by the remaining byte from bits [23:16].
module crc_tail_slicer
  import crc_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [LEN_W-1:0] rem,
  input  logic             split,
  input  logic [31:0]      word,
  output logic [1:0]       size,
  output logic [31:0]      wdata,
  output logic [2:0]       nbytes
);

  // Map the remaining length onto the widest write that does not overrun.
  always_comb begin
    size   = SIZE_BYTE;
    wdata  = '0;
    nbytes = 3'd0;
    if (split) begin
      size   = SIZE_BYTE;
      wdata  = {24'h0, word[23:16]};
      nbytes = 3'd1;
    end else if (rem >= LEN_W'(4)) begin
      size   = SIZE_WORD;
      wdata  = word;
      nbytes = 3'd4;
    end else if (rem == LEN_W'(3) || rem == LEN_W'(2)) begin
      size   = SIZE_HALF_WORD;
      wdata  = {16'h0, word[15:0]};
      nbytes = 3'd2;
    end else if (rem == LEN_W'(1)) begin
      size   = SIZE_BYTE;
      wdata  = {24'h0, word[7:0]};
      nbytes = 3'd1;
    end
  end

endmodule

// File: rtl/crc_stream_feeder.sv
// CRC stream feeder: fetches a memory block one 32-bit word at a time over a
// req/ack port and streams it into the CRC unit's write interface, honouring
// buffer_full back-pressure. Optionally breaks the CRC chain on the last write,
// waits for the CRC pipeline to drain and captures the result.
module crc_stream_feeder
  import crc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  byte_len,
  input  logic              keep_chain,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       crc_result,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              crc_write,
  output logic [1:0]        crc_size,
  output logic [31:0]       crc_wdata,
  output logic              crc_reset_chain,
  input  logic              crc_buffer_full,
  input  logic              crc_read_wait,
  input  logic [31:0]       crc_out
);

  // Start addresses are forced onto a word boundary.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  feeder_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  rem_reg, rem_next;
  logic [31:0]       word_reg, word_next;
  logic              chain_reg, chain_next;
  logic              aborted_reg, aborted_next;
  logic              abort_pend_reg, abort_pend_next;   // abort seen while a read is in flight
  logic              abort_drain_reg, abort_drain_next; // first DRAIN cycle after an abort
  logic [31:0]       crc_result_reg, crc_result_next;

  logic [1:0]        slice_size;
  logic [31:0]       slice_wdata;
  logic [2:0]        slice_nbytes;
  logic [LEN_W-1:0]  nbytes_ext;
  logic              final_write;

  crc_tail_slicer #(
    .LEN_W (LEN_W)
  ) u_slicer (
    .rem    (rem_reg),
    .split  (state_reg == ST_SPLIT),
    .word   (word_reg),
    .size   (slice_size),
    .wdata  (slice_wdata),
    .nbytes (slice_nbytes)
  );

  assign nbytes_ext  = LEN_W'(slice_nbytes);
  assign final_write = (rem_reg == nbytes_ext);

  // State and datapath registers; everything clears under reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      rem_reg         <= '0;
      word_reg        <= '0;
      chain_reg       <= 1'b0;
      aborted_reg     <= 1'b0;
      abort_pend_reg  <= 1'b0;
      abort_drain_reg <= 1'b0;
      crc_result_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      rem_reg         <= rem_next;
      word_reg        <= word_next;
      chain_reg       <= chain_next;
      aborted_reg     <= aborted_next;
      abort_pend_reg  <= abort_pend_next;
      abort_drain_reg <= abort_drain_next;
      crc_result_reg  <= crc_result_next;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    rem_next         = rem_reg;
    word_next        = word_reg;
    chain_next       = chain_reg;
    aborted_next     = aborted_reg;
    abort_pend_next  = abort_pend_reg;
    abort_drain_next = 1'b0;
    crc_result_next  = crc_result_reg;
    busy             = (state_reg != ST_IDLE);
    done             = 1'b0;
    mem_req          = 1'b0;
    mem_addr         = '0;
    crc_write        = 1'b0;
    crc_reset_chain  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          aborted_next    = 1'b0;
          abort_pend_next = 1'b0;
          if (byte_len != '0) begin
            addr_next  = src_addr & WORD_MASK;
            rem_next   = byte_len;
            chain_next = keep_chain;
            state_next = ST_FETCH;
          end else begin
            // Empty job: no memory or CRC traffic, just report completion.
            state_next = ST_FINISH;
          end
        end
      end

      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = addr_reg;
        if (mem_ack) begin
          word_next = mem_rdata;
          addr_next = addr_reg + ADDR_W'(4);
          if (abort || abort_pend_reg) begin
            // The read has completed, so nothing is outstanding: cancel now.
            aborted_next     = 1'b1;
            abort_pend_next  = 1'b0;
            abort_drain_next = 1'b1;
            state_next       = ST_DRAIN;
          end else begin
            state_next = ST_WRITE;
          end
        end else if (abort) begin
          abort_pend_next = 1'b1;
        end
      end

      ST_WRITE: begin
        if (abort) begin
          // Writes complete in the cycle they are issued, so an abort here
          // simply withholds the pending write.
          aborted_next     = 1'b1;
          abort_drain_next = 1'b1;
          state_next       = ST_DRAIN;
        end else if (!crc_buffer_full) begin
          crc_write       = 1'b1;
          rem_next        = rem_reg - nbytes_ext;
          crc_reset_chain = final_write & ~chain_reg;
          if (final_write) begin
            state_next = ST_DRAIN;
          end else if (rem_reg == LEN_W'(3)) begin
            state_next = ST_SPLIT;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end

      ST_SPLIT: begin
        // Last byte of a 3-byte tail; always the final write of the job.
        if (!crc_buffer_full) begin
          crc_write       = 1'b1;
          rem_next        = rem_reg - nbytes_ext;
          crc_reset_chain = ~chain_reg;
          state_next      = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        crc_reset_chain = abort_drain_reg;
        if (!crc_read_wait) begin
          state_next = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done            = 1'b1;
        crc_result_next = crc_out;
        state_next      = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Size/data are only meaningful alongside the write strobe; keep them quiet otherwise.
  assign crc_size   = crc_write ? slice_size : SIZE_BYTE;
  assign crc_wdata  = crc_write ? slice_wdata : '0;
  assign aborted    = done & aborted_reg;
  assign crc_result = crc_result_reg;

endmodule

// File: tb/tb_crc_stream_feeder.sv
// Scoreboard bench for crc_stream_feeder: directed jobs push expected memory
// addresses, CRC writes and completions into queues; a memory responder and a
// monitor pop and compare as the DUT produces them.
module tb_crc_stream_feeder;
  import crc_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [LEN_W-1:0]  byte_len;
  logic              keep_chain;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [31:0]       crc_result;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              crc_write;
  logic [1:0]        crc_size;
  logic [31:0]       crc_wdata;
  logic              crc_reset_chain;
  logic              crc_buffer_full;
  logic              crc_read_wait;
  logic [31:0]       crc_out;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] data;
    logic        rc;
  } wr_t;

  typedef struct packed {
    logic        ab;
    logic [31:0] result;
  } done_t;

  wr_t               exp_wr_q[$];
  done_t             exp_done_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_solo_rc;
  int                n_checks;
  int                n_fail;
  int                ack_delay;
  int                wait_cnt;
  int                n_done;
  logic              pend;
  logic [31:0]       pend_val;
  wr_t               cur_wr;
  done_t             cur_done;

  crc_stream_feeder #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .src_addr        (src_addr),
    .byte_len        (byte_len),
    .keep_chain      (keep_chain),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .crc_result      (crc_result),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .crc_write       (crc_write),
    .crc_size        (crc_size),
    .crc_wdata       (crc_wdata),
    .crc_reset_chain (crc_reset_chain),
    .crc_buffer_full (crc_buffer_full),
    .crc_read_wait   (crc_read_wait),
    .crc_out         (crc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s, expected none", name, what);
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    case (a)
      32'h0000_0100: return 32'h1122_3344;
      32'h0000_0104: return 32'h5566_7788;
      default:       return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  task automatic push_wr(input logic [1:0] s, input logic [31:0] d, input logic rc);
    wr_t e;
    e.size = s;
    e.data = d;
    e.rc   = rc;
    exp_wr_q.push_back(e);
  endtask

  task automatic push_done(input logic ab, input logic [31:0] res);
    done_t e;
    e.ab     = ab;
    e.result = res;
    exp_done_q.push_back(e);
  endtask

  // Memory responder: acks after ack_delay waiting cycles, checks the address.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && rst_n) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_cnt  = 0;
          $display("mem read addr=0x%08h data=0x%08h", mem_addr, mem_rdata);
          if (exp_addr_q.size() == 0) begin
            flag("unexpected_mem_req", $sformatf("read of 0x%08h", mem_addr));
          end else begin
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
          end
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares every CRC write, solo chain break and completion.
  initial begin
    pend     = 1'b0;
    pend_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("crc_result_after_done", 64'(crc_result), 64'(pend_val));
          chk("busy_low_after_done", 64'(busy), 64'd0);
          pend = 1'b0;
        end
        if (crc_write) begin
          $display("crc write size=%0d data=0x%08h reset_chain=%0d", crc_size, crc_wdata, crc_reset_chain);
          chk("write_while_full", 64'(crc_buffer_full), 64'd0);
          if (exp_wr_q.size() == 0) begin
            flag("unexpected_write", $sformatf("size=%0d data=0x%08h", crc_size, crc_wdata));
          end else begin
            cur_wr = exp_wr_q.pop_front();
            chk("wr_size", 64'(crc_size), 64'(cur_wr.size));
            chk("wr_data", 64'(crc_wdata), 64'(cur_wr.data));
            chk("wr_reset_chain", 64'(crc_reset_chain), 64'(cur_wr.rc));
          end
        end else if (crc_reset_chain) begin
          $display("crc chain break without write");
          chk("solo_reset_chain_expected", 64'(exp_solo_rc > 0), 64'd1);
          if (exp_solo_rc > 0) exp_solo_rc--;
        end
        if (done) begin
          n_done++;
          $display("done aborted=%0d", aborted);
          if (exp_done_q.size() == 0) begin
            flag("unexpected_done", "done pulse");
          end else begin
            cur_done = exp_done_q.pop_front();
            chk("done_aborted", 64'(aborted), 64'(cur_done.ab));
            chk("busy_at_done", 64'(busy), 64'd1);
            pend     = 1'b1;
            pend_val = cur_done.result;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len, input logic kc);
    src_addr   = a;
    byte_len   = len;
    keep_chain = kc;
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_writes(input int budget);
    int i;
    i = 0;
    while ((exp_wr_q.size() != 0 || exp_addr_q.size() != 0) && i < budget) begin
      cyc(1);
      i++;
    end
    chk("traffic_drained_in_time", 64'(exp_wr_q.size() + exp_addr_q.size()), 64'd0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int i;
    i = 0;
    while (n_done < target && i < budget) begin
      cyc(1);
      i++;
    end
    chk("done_count", 64'(n_done), 64'(target));
    cyc(1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_aborted"}, 64'(aborted), 64'd0);
    chk({tag, "_crc_result"}, 64'(crc_result), 64'd0);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_crc_write"}, 64'(crc_write), 64'd0);
    chk({tag, "_crc_size"}, 64'(crc_size), 64'd0);
    chk({tag, "_crc_wdata"}, 64'(crc_wdata), 64'd0);
    chk({tag, "_reset_chain"}, 64'(crc_reset_chain), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    n_done          = 0;
    exp_solo_rc     = 0;
    ack_delay       = 0;
    rst_n           = 1'b0;
    start           = 1'b0;
    src_addr        = '0;
    byte_len        = '0;
    keep_chain      = 1'b0;
    abort           = 1'b0;
    crc_buffer_full = 1'b0;
    crc_read_wait   = 1'b0;
    crc_out         = '0;
    cyc(3);
    check_idle("reset");
    rst_n = 1'b1;
    cyc(1);

    // Job 1: 8 bytes, chain broken on the second WORD, done waits for read_wait.
    crc_out       = 32'hCAFE_0001;
    crc_read_wait = 1'b1;
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    push_wr(SIZE_WORD, 32'h1122_3344, 1'b0);
    push_wr(SIZE_WORD, 32'h5566_7788, 1'b1);
    launch(32'h100, 16'd8, 1'b0);
    wait_writes(40);
    cyc(3);
    chk("no_done_while_read_wait", 64'(n_done), 64'd0);
    push_done(1'b0, 32'hCAFE_0001);
    crc_read_wait = 1'b0;
    wait_done(1, 20);

    // Job 2: 7 bytes -> WORD, HALF_WORD 0x7788, BYTE 0x66 with the chain break.
    crc_out = 32'hCAFE_0002;
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    push_wr(SIZE_WORD, 32'h1122_3344, 1'b0);
    push_wr(SIZE_HALF_WORD, 32'h0000_7788, 1'b0);
    push_wr(SIZE_BYTE, 32'h0000_0066, 1'b1);
    push_done(1'b0, 32'hCAFE_0002);
    launch(32'h100, 16'd7, 1'b0);
    wait_done(2, 40);

    // Job 3: 5 bytes from an unaligned address, buffer full for 10 cycles.
    crc_out         = 32'hCAFE_0003;
    crc_buffer_full = 1'b1;
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    push_wr(SIZE_WORD, 32'h1122_3344, 1'b0);
    push_wr(SIZE_BYTE, 32'h0000_0088, 1'b1);
    push_done(1'b0, 32'hCAFE_0003);
    launch(32'h102, 16'd5, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk("no_write_when_full", 64'(crc_write), 64'd0);
    end
    chk("held_write_count", 64'(exp_wr_q.size()), 64'd2);
    crc_buffer_full = 1'b0;
    wait_done(3, 40);

    // Job 4: zero length -> completion only, no traffic.
    crc_out = 32'hCAFE_0004;
    push_done(1'b0, 32'hCAFE_0004);
    launch(32'h100, 16'd0, 1'b0);
    wait_done(4, 10);

    // Jobs 5/6: chained 4-byte jobs; a start during the first is ignored.
    crc_out       = 32'hCAFE_0005;
    crc_read_wait = 1'b1;
    exp_addr_q.push_back(32'h100);
    push_wr(SIZE_WORD, 32'h1122_3344, 1'b0);
    launch(32'h100, 16'd4, 1'b1);
    wait_writes(40);
    cyc(2);
    launch(32'h104, 16'd4, 1'b1);
    cyc(3);
    chk("busy_through_drain", 64'(busy), 64'd1);
    push_done(1'b0, 32'hCAFE_0005);
    crc_read_wait = 1'b0;
    wait_done(5, 20);
    crc_out = 32'hCAFE_0006;
    exp_addr_q.push_back(32'h104);
    push_wr(SIZE_WORD, 32'h5566_7788, 1'b0);
    push_done(1'b0, 32'hCAFE_0006);
    launch(32'h104, 16'd4, 1'b1);
    wait_done(6, 30);

    // Job 7: abort during a slow fetch; one solo chain break even with keep_chain=1.
    ack_delay   = 3;
    crc_out     = 32'hCAFE_0007;
    exp_addr_q.push_back(32'h100);
    exp_solo_rc = 1;
    push_done(1'b1, 32'hCAFE_0007);
    launch(32'h100, 16'd8, 1'b1);
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_done(7, 30);
    chk("solo_reset_chain_consumed", 64'(exp_solo_rc), 64'd0);
    ack_delay = 0;

    // Job 8: reset pulsed while stuck in WRITE; everything idle next cycle.
    crc_out         = 32'hCAFE_0008;
    crc_buffer_full = 1'b1;
    exp_addr_q.push_back(32'h100);
    launch(32'h100, 16'd8, 1'b0);
    wait_writes(20);
    cyc(2);
    chk("stalled_in_write", 64'(crc_write), 64'd0);
    rst_n = 1'b0;
    cyc(1);
    check_idle("reset_mid_write");
    rst_n           = 1'b1;
    crc_buffer_full = 1'b0;
    cyc(5);
    chk("idle_after_reset_busy", 64'(busy), 64'd0);
    chk("no_done_after_reset", 64'(n_done), 64'd7);

    chk("write_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    chk("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
